// File: rtl/reg_write_arbiter_if.sv
// Bundle of the request/data inputs and the register/grant outputs of the
// two-requester register write arbiter.
// master: requester side (drives req/data, observes grants and register).
// slave : arbiter side (observes req/data, drives grants and register).
interface reg_write_arbiter_if;
  logic       req0;      // write request, requester 0
  logic [3:0] d0;        // write data, requester 0
  logic       req1;      // write request, requester 1
  logic [3:0] d1;        // write data, requester 1
  logic       gnt0;      // one-cycle grant, requester 0
  logic       gnt1;      // one-cycle grant, requester 1
  logic [3:0] q;         // shared register contents
  logic       valid;     // q has been written since reset
  logic       owner;     // id of last requester written to q
  logic [7:0] wr_count;  // completed writes since reset, mod 256

  modport master (
    output req0, d0, req1, d1,
    input  gnt0, gnt1, q, valid, owner, wr_count
  );

  modport slave (
    input  req0, d0, req1, d1,
    output gnt0, gnt1, q, valid, owner, wr_count
  );
endinterface

// File: rtl/reg_write_arbiter.sv
// Purpose: round-robin arbiter granting two requesters writes into one shared 4-bit register.
// Latency: one edge from sampled request to grant/q update; at most one write per two cycles.
// Backpressure: none; requests seen during the GRANT cycle are dropped, a held request re-arbitrates in IDLE.
// Ports: clk (rising edge), reset (async, active-high), bus (slave modport:
//        req0/d0, req1/d1 in; gnt0/gnt1, q, valid, owner, wr_count out, all from flops).
module reg_write_arbiter (
  input  logic                 clk,
  input  logic                 reset,
  reg_write_arbiter_if.slave   bus
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] q_q, q_d;
  logic       gnt0_q, gnt0_d;
  logic       gnt1_q, gnt1_d;
  logic       valid_q, valid_d;
  logic       owner_q, owner_d;
  logic [7:0] wr_count_q, wr_count_d;
  logic       last_winner_q, last_winner_d;
  logic       pick1;

  // Async reset clears everything immediately, including a grant in flight,
  // so an interrupted write leaves no trace in q or wr_count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      q_q           <= 4'b0000;
      gnt0_q        <= 1'b0;
      gnt1_q        <= 1'b0;
      valid_q       <= 1'b0;
      owner_q       <= 1'b0;
      wr_count_q    <= 8'd0;
      last_winner_q <= 1'b1;  // makes the first tie after reset go to requester 0
    end else begin
      state_q       <= state_d;
      q_q           <= q_d;
      gnt0_q        <= gnt0_d;
      gnt1_q        <= gnt1_d;
      valid_q       <= valid_d;
      owner_q       <= owner_d;
      wr_count_q    <= wr_count_d;
      last_winner_q <= last_winner_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    q_d           = q_q;
    gnt0_d        = 1'b0;
    gnt1_d        = 1'b0;
    valid_d       = valid_q;
    owner_d       = owner_q;
    wr_count_d    = wr_count_q;
    last_winner_d = last_winner_q;
    // Requester 1 wins when it is alone, or on a tie when requester 0 won last.
    pick1         = bus.req1 & (~bus.req0 | ~last_winner_q);

    unique case (state_q)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          state_d       = GRANT;
          gnt0_d        = ~pick1;
          gnt1_d        = pick1;
          q_d           = pick1 ? bus.d1 : bus.d0;
          owner_d       = pick1;
          last_winner_d = pick1;
          valid_d       = 1'b1;
          wr_count_d    = wr_count_q + 8'd1;
        end
      end
      GRANT: begin
        // Single grant cycle; inputs are deliberately not looked at here.
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.gnt0     = gnt0_q;
  assign bus.gnt1     = gnt1_q;
  assign bus.q        = q_q;
  assign bus.valid    = valid_q;
  assign bus.owner    = owner_q;
  assign bus.wr_count = wr_count_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Bench for reg_write_arbiter: directed scenarios plus randomized traffic
// compared against a cycle-level behavioural model of the arbiter rules.
module tb_reg_write_arbiter;

  logic clk;
  logic reset;
  reg_write_arbiter_if bus ();

  reg_write_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int tests_run    = 0;
  int tests_failed = 0;

  // Behavioural model state.
  logic [3:0] m_q;
  logic       m_valid, m_owner, m_lw, m_busy, m_g0, m_g1;
  logic [7:0] m_cnt;

  task automatic model_reset();
    m_q = 4'h0; m_valid = 1'b0; m_owner = 1'b0; m_lw = 1'b1;
    m_busy = 1'b0; m_g0 = 1'b0; m_g1 = 1'b0; m_cnt = 8'd0;
  endtask

  // Advance one rising edge; the model applies the arbitration rules to the
  // request/data values present at that edge. Returns #1 after the edge.
  task automatic tick();
    logic r0, r1, w;
    @(posedge clk);
    r0 = bus.req0;
    r1 = bus.req1;
    if (m_busy) begin
      m_busy = 1'b0; m_g0 = 1'b0; m_g1 = 1'b0;
    end else if (r0 || r1) begin
      w       = (r0 && r1) ? ~m_lw : r1;
      m_g0    = ~w;
      m_g1    = w;
      m_q     = w ? bus.d1 : bus.d0;
      m_owner = w;
      m_lw    = w;
      m_valid = 1'b1;
      m_cnt   = m_cnt + 8'd1;
      m_busy  = 1'b1;
    end else begin
      m_g0 = 1'b0; m_g1 = 1'b0;
    end
    #1;
  endtask

  // Pulse reset away from clock edges and resynchronise the model.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    #2;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    // Pulse before the first clock edge (first posedge at t=5).
    #1 reset = 1'b1;
    #1 reset = 1'b0;
    #1;
    model_reset();
    tests_run++;
    if ({bus.gnt0, bus.gnt1, bus.q, bus.valid, bus.owner, bus.wr_count} !== 16'h0) begin
      tests_failed++;
      $display("FAIL reset_state: got gnt0=%b gnt1=%b q=%h valid=%b owner=%b cnt=%0d expected all zero",
               bus.gnt0, bus.gnt1, bus.q, bus.valid, bus.owner, bus.wr_count);
    end
  endtask

  task automatic test_single_write();
    do_reset();
    bus.req0 = 1'b1; bus.d0 = 4'hA;
    tick();
    bus.req0 = 1'b0;
    tests_run++;
    if ({bus.gnt0, bus.gnt1, bus.q, bus.owner, bus.valid, bus.wr_count} !== {1'b1, 1'b0, 4'hA, 1'b0, 1'b1, 8'd1}) begin
      tests_failed++;
      $display("FAIL single_write: got gnt0=%b gnt1=%b q=%h owner=%b valid=%b cnt=%0d expected 1 0 a 0 1 1",
               bus.gnt0, bus.gnt1, bus.q, bus.owner, bus.valid, bus.wr_count);
    end
    tick();
    tests_run++;
    if ({bus.gnt0, bus.q, bus.wr_count} !== {1'b0, 4'hA, 8'd1}) begin
      tests_failed++;
      $display("FAIL single_grant_one_cycle: got gnt0=%b q=%h cnt=%0d expected 0 a 1",
               bus.gnt0, bus.q, bus.wr_count);
    end
  endtask

  task automatic test_tie_round_robin();
    logic prev_g;
    logic eg0, eg1;
    logic [3:0] eq;
    do_reset();
    bus.req0 = 1'b1; bus.d0 = 4'h3;
    bus.req1 = 1'b1; bus.d1 = 4'hC;
    prev_g = 1'b0;
    eq = 4'h0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      eg0 = (k % 2 == 1) && (((k - 1) / 2) % 2 == 0);
      eg1 = (k % 2 == 1) && (((k - 1) / 2) % 2 == 1);
      if (eg0) eq = 4'h3;
      if (eg1) eq = 4'hC;
      tests_run++;
      if ({bus.gnt0, bus.gnt1, bus.q} !== {eg0, eg1, eq}) begin
        tests_failed++;
        $display("FAIL tie_rr_cycle%0d: got gnt0=%b gnt1=%b q=%h expected %b %b %h",
                 k, bus.gnt0, bus.gnt1, bus.q, eg0, eg1, eq);
      end
      tests_run++;
      if (prev_g && (bus.gnt0 || bus.gnt1)) begin
        tests_failed++;
        $display("FAIL tie_rr_consecutive%0d: got grant on consecutive cycles expected gap", k);
      end
      prev_g = bus.gnt0 | bus.gnt1;
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
  endtask

  task automatic test_wrap();
    int ngr;
    do_reset();
    bus.req1 = 1'b1; bus.d1 = 4'h5;
    ngr = 0;
    for (int k = 0; k < 512; k++) begin
      tick();
      if (bus.gnt1) ngr++;
    end
    bus.req1 = 1'b0;
    tests_run++;
    if (ngr != 256) begin
      tests_failed++;
      $display("FAIL wrap_grants: got %0d expected 256", ngr);
    end
    tests_run++;
    if ({bus.wr_count, bus.valid} !== {8'd0, 1'b1}) begin
      tests_failed++;
      $display("FAIL wrap_count: got cnt=%0d valid=%b expected 0 1", bus.wr_count, bus.valid);
    end
    tick();
  endtask

  task automatic test_reset_during_grant();
    do_reset();
    bus.req1 = 1'b1; bus.d1 = 4'h7;
    tick();
    bus.req1 = 1'b0;
    tests_run++;
    if ({bus.gnt1, bus.q} !== {1'b1, 4'h7}) begin
      tests_failed++;
      $display("FAIL rst_grant_pre: got gnt1=%b q=%h expected 1 7", bus.gnt1, bus.q);
    end
    #2 reset = 1'b1;
    #1;
    tests_run++;
    if ({bus.gnt1, bus.gnt0, bus.q, bus.wr_count, bus.valid} !== {1'b0, 1'b0, 4'h0, 8'd0, 1'b0}) begin
      tests_failed++;
      $display("FAIL rst_grant_drop: got gnt1=%b gnt0=%b q=%h cnt=%0d valid=%b expected 0 0 0 0 0",
               bus.gnt1, bus.gnt0, bus.q, bus.wr_count, bus.valid);
    end
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    tick();
    tests_run++;
    if ({bus.gnt1, bus.wr_count} !== {1'b0, 8'd0}) begin
      tests_failed++;
      $display("FAIL rst_grant_after: got gnt1=%b cnt=%0d expected 0 0", bus.gnt1, bus.wr_count);
    end
  endtask

  task automatic test_ignore_during_grant();
    logic seen_g0;
    do_reset();
    bus.req1 = 1'b1; bus.d1 = 4'h9;
    tick();
    bus.req1 = 1'b0;
    bus.req0 = 1'b1; bus.d0 = 4'h2;  // present only in the GRANT cycle
    seen_g0 = bus.gnt0;
    tick();
    bus.req0 = 1'b0;
    seen_g0 |= bus.gnt0;
    tick();
    seen_g0 |= bus.gnt0;
    tick();
    seen_g0 |= bus.gnt0;
    tests_run++;
    if ({seen_g0, bus.q, bus.wr_count, bus.owner} !== {1'b0, 4'h9, 8'd1, 1'b1}) begin
      tests_failed++;
      $display("FAIL ignore_in_grant: got gnt0_seen=%b q=%h cnt=%0d owner=%b expected 0 9 1 1",
               seen_g0, bus.q, bus.wr_count, bus.owner);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 400; k++) begin
      bus.req0 = 1'($urandom_range(0, 1));
      bus.req1 = 1'($urandom_range(0, 1));
      bus.d0   = 4'($urandom);
      bus.d1   = 4'($urandom);
      tick();
      tests_run++;
      if ({bus.gnt0, bus.gnt1, bus.q, bus.valid, bus.owner, bus.wr_count} !==
          {m_g0, m_g1, m_q, m_valid, m_owner, m_cnt}) begin
        tests_failed++;
        $display("FAIL random_cycle%0d: got g0=%b g1=%b q=%h v=%b own=%b cnt=%0d expected %b %b %h %b %b %0d",
                 k, bus.gnt0, bus.gnt1, bus.q, bus.valid, bus.owner, bus.wr_count,
                 m_g0, m_g1, m_q, m_valid, m_owner, m_cnt);
      end
      tests_run++;
      if (bus.gnt0 && bus.gnt1) begin
        tests_failed++;
        $display("FAIL random_mutex%0d: got both grants expected at most one", k);
      end
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
  endtask

  initial begin
    reset    = 1'b0;
    bus.req0 = 1'b0; bus.d0 = 4'h0;
    bus.req1 = 1'b0; bus.d1 = 4'h0;
    model_reset();
    test_reset();
    test_single_write();
    test_tie_round_robin();
    test_wrap();
    test_reset_during_grant();
    test_ignore_during_grant();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/reg_write_arbiter.md
REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

Interface
REQ-001 SHALL have port: clk  input  1  single system clock; all state updates on rising edge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port: req0  input  1  write request, requester 0.
REQ-004 SHALL have port: d0  input  4  write data, requester 0.
REQ-005 SHALL have port: req1  input  1  write request, requester 1.
REQ-006 SHALL have port: d1  input  4  write data, requester 1.
REQ-007 SHALL have port: gnt0  output  1  registered one-cycle grant, requester 0.
REQ-008 SHALL have port: gnt1  output  1  registered one-cycle grant, requester 1.
REQ-009 SHALL have port: q  output  4  shared 4-bit register contents.
REQ-010 SHALL have port: valid  output  1  q holds at least one written value since reset.
REQ-011 SHALL have port: owner  output  1  id of last requester written to q.
REQ-012 SHALL have port: wr_count  output  8  number of completed writes since reset, modulo 256.

Function
REQ-013 SHALL implement a two-state FSM: IDLE and GRANT.
REQ-014 IDLE, no request sampled: SHALL remain IDLE, all outputs hold their values, gnt0=gnt1=0.
REQ-015 IDLE, only req0 high at the rising edge: SHALL go to GRANT with gnt0=1, q<=d0, owner<=0.
REQ-016 IDLE, only req1 high at the rising edge: SHALL go to GRANT with gnt1=1, q<=d1, owner<=1.
REQ-017 IDLE, req0 and req1 both high: SHALL grant the requester that is not last_winner (round robin).
REQ-018 The internal last_winner bit SHALL update to the granted id on every grant.
REQ-019 Data SHALL be sampled on the same edge that decides the grant; write latency is one edge from the sampled request to q update.
REQ-020 GRANT SHALL last exactly one cycle and SHALL then return to IDLE unconditionally; sustained throughput is at most one write per two cycles.
REQ-021 Requests present during the GRANT cycle SHALL be ignored; requests are sampled again only in IDLE.
REQ-022 A req still high in the IDLE cycle after its grant SHALL be treated as a new request and arbitrated normally.
REQ-023 gnt0 and gnt1 SHALL be mutually exclusive and SHALL never both be 1.
REQ-024 On each write, wr_count SHALL increment by 1, wrapping 255->0 with no flag.
REQ-025 valid SHALL set to 1 on the first write and SHALL stay 1 until reset.
REQ-026 q SHALL change only on a grant edge.
REQ-027 All outputs SHALL be driven directly from flops, with no combinational path from inputs to outputs.

Reset
REQ-028 While reset=1, independent of clk: state=IDLE, q=4'b0000, gnt0=gnt1=0, valid=0, owner=0, wr_count=0, last_winner=1.
REQ-029 On a simultaneous tie, the first grant after reset SHALL go to requester 0.
REQ-030 Reset asserted during GRANT SHALL drop the gnt signal at once, with no clock edge, and SHALL abandon the write.
REQ-031 The first arbitration SHALL occur at the first rising edge after reset deasserts.

Verification
REQ-032 Reset pulse with no clocks -> q=0, gnt0=gnt1=0, valid=0, owner=0, wr_count=0.
REQ-033 req0=1, d0=4'hA for one edge -> gnt0=1 for exactly one cycle, q=4'hA, owner=0, valid=1, wr_count=1.
REQ-034 req0=req1=1 held, d0=4'h3, d1=4'hC -> grants follow 0,1,0,1 on every second cycle, q follows 3,C,3,C, and gnt is never high on consecutive cycles.
REQ-035 req1 held high for 512 cycles -> 256 grants, after which wr_count wraps to 0 and valid stays 1.
REQ-036 Reset asserted mid-cycle while gnt1=1 -> gnt1=0 and q=0 within the same timestep, and wr_count does not increment.
REQ-037 req0 pulsed only during the GRANT cycle of requester 1 -> no gnt0 is issued, q is unchanged, and wr_count is unchanged.
